register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, legal range 1..4.
REQ-004 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port ReadRegister  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port ReadData  output  NUM_RD*DATA_W  packed read data for port k.
REQ-008 SHALL have port ReadBusy  output  NUM_RD  pending flag of the register addressed by read port k.
REQ-009 SHALL have ports WriteRegister (input, ADDR_W), WriteData (input, DATA_W) and RegWrite (input, 1): write port A.
REQ-010 SHALL have ports WriteRegister2 (input, ADDR_W), WriteData2 (input, DATA_W) and RegWrite2 (input, 1): write port B.
REQ-011 SHALL have ports ReserveRegister (input, ADDR_W) and Reserve (input, 1): marks a register pending.

Function
REQ-012 Read ports SHALL be combinational: ReadData[k] = stored value of ReadRegister[k], with zero clock latency.
REQ-013 A write SHALL commit on the rising edge of Clk when its RegWrite is 1; the new value is visible on reads from the next cycle.
REQ-014 Register 0 SHALL always read 0 and SHALL never be busy; writes and reserves to address 0 SHALL be ignored.
REQ-015 When both write ports target the same address in one cycle, port A SHALL win and port B's data SHALL be discarded.
REQ-016 Pending bit of register r SHALL set on a clock edge with Reserve=1 and ReserveRegister=r.
REQ-017 Pending bit of register r SHALL clear on a clock edge where either write port writes r.
REQ-018 If a reserve and a write to the same r occur on one edge, the reserve SHALL win and r ends pending with the new data stored.
REQ-019 ReadBusy[k] SHALL equal the pending bit of ReadRegister[k], combinational.
REQ-020 All addresses 0..2**ADDR_W-1 SHALL be valid; no address wrap or aliasing.

Reset
REQ-021 Reset=1 SHALL immediately clear all registers to 0 and all pending bits to 0, independent of Clk.
REQ-022 While Reset=1, ReadData SHALL be all 0, ReadBusy SHALL be 0, and writes and reserves SHALL be ignored.
REQ-023 Reset asserted mid-write SHALL discard that write; on the first edge after deassertion, normal operation SHALL resume.

Configuration
REQ-024 With macro RF_BYPASS_EN defined, a read whose address matches an active write (RegWrite or RegWrite2, nonzero address) SHALL return that write's WriteData in the same cycle, using port A priority.
REQ-025 With RF_BYPASS_EN defined, ReadBusy SHALL read 0 for that address in that cycle, unless a same-cycle reserve hits the address.
REQ-026 Without RF_BYPASS_EN, reads SHALL return the stored value only, per REQ-012.

Structure
REQ-027 Shared package rf_pkg SHALL hold the default constants RF_DATA_W=32, RF_ADDR_W=5 and RF_NUM_RD=2, plus the typedefs rf_addr_t and rf_data_t.
REQ-028 One sub-module, rf_read_port, SHALL implement a single read port (select, bypass, busy lookup); it is instantiated NUM_RD times by generate.

Verification
REQ-029 Scenario: write 5*i to regs 8..26 via port A, one per cycle, then read pairs (i, i+1) -> ReadData = 5*i and 5*(i+1).
REQ-030 Scenario: write 0xDEADBEEF to reg 0, then read reg 0 -> 0; ReadBusy = 0 after Reserve on reg 0.
REQ-031 Scenario: same edge, port A writes reg 9 = 0x11 and port B writes reg 9 = 0x22 -> reg 9 reads 0x11.
REQ-032 Scenario: Reserve reg 12 -> ReadBusy = 1; port B writes 0x7 to reg 12 -> busy 0 and data 0x7; reserve and write reg 12 on one edge -> busy 1 and data updated.
REQ-033 Scenario: read reg 10 while port A writes 0x55 to it -> 0x55 in the same cycle with RF_BYPASS_EN, old value without it.
REQ-034 Scenario: fill regs 1..31, pulse Reset between clock edges -> all reads 0 and busy 0 immediately; the write in progress is lost.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

    parameter int RF_DATA_W = 32;
    parameter int RF_ADDR_W = 5;
    parameter int RF_NUM_RD = 2;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register select, pending-bit lookup and optional
// same-cycle write bypass (RF_BYPASS_EN).
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0]                  readAddr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regVals,
    input  logic [2**ADDR_W-1:0]               pendBits,
    output logic [DATA_W-1:0]                  readData,
    output logic                               readBusy
`ifdef RF_BYPASS_EN
    ,
    input  logic                               wrEnA,
    input  logic [ADDR_W-1:0]                  wrAddrA,
    input  logic [DATA_W-1:0]                  wrDataA,
    input  logic                               wrEnB,
    input  logic [ADDR_W-1:0]                  wrAddrB,
    input  logic [DATA_W-1:0]                  wrDataB,
    input  logic                               rsvEn,
    input  logic [ADDR_W-1:0]                  rsvAddr
`endif
);

    always_comb begin
        readData = regVals[readAddr];
        readBusy = pendBits[readAddr];
`ifdef RF_BYPASS_EN
        // Enables arrive pre-qualified (nonzero address, not in reset); A outranks B.
        if (wrEnA && (wrAddrA == readAddr)) begin
            readData = wrDataA;
            readBusy = 1'b0;
        end else if (wrEnB && (wrAddrB == readAddr)) begin
            readData = wrDataB;
            readBusy = 1'b0;
        end
        if (rsvEn && (rsvAddr == readAddr)) begin
            readBusy = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports and per-register
// pending bits. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadBusy,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister2,
    input  logic [DATA_W-1:0]        WriteData2,
    input  logic                     RegWrite2,
    input  logic [ADDR_W-1:0]        ReserveRegister,
    input  logic                     Reserve
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regVals;
    logic [DEPTH-1:0]             pendBits;
    logic                         wrEnA;
    logic                         wrEnB;
    logic                         rsvEn;

    // Register 0 is never written or reserved, so it stays at its reset value of zero.
    always_comb begin
        wrEnA = RegWrite && (WriteRegister != '0) && !Reset;
        wrEnB = RegWrite2 && (WriteRegister2 != '0) && !Reset &&
                !(wrEnA && (WriteRegister2 == WriteRegister));
        rsvEn = Reserve && (ReserveRegister != '0) && !Reset;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regVals  <= '0;
            pendBits <= '0;
        end else begin
            if (wrEnA) begin
                regVals[WriteRegister]  <= WriteData;
                pendBits[WriteRegister] <= 1'b0;
            end
            if (wrEnB) begin
                regVals[WriteRegister2]  <= WriteData2;
                pendBits[WriteRegister2] <= 1'b0;
            end
            // Last assignment wins: a reserve overrides a same-edge write clear.
            if (rsvEn) begin
                pendBits[ReserveRegister] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_read_port (
            .readAddr (ReadRegister[k*ADDR_W +: ADDR_W]),
            .regVals  (regVals),
            .pendBits (pendBits),
            .readData (ReadData[k*DATA_W +: DATA_W]),
            .readBusy (ReadBusy[k])
`ifdef RF_BYPASS_EN
            ,
            .wrEnA    (wrEnA),
            .wrAddrA  (WriteRegister),
            .wrDataA  (WriteData),
            .wrEnB    (wrEnB),
            .wrAddrB  (WriteRegister2),
            .wrDataB  (WriteData2),
            .rsvEn    (rsvEn),
            .rsvAddr  (ReserveRegister)
`endif
        );
    end

endmodule
